// File: rtl/pingpong_frame_reader.sv
// Ping-pong bank reader: streams a freshly filled RAM bank as one valid/ready frame,
// keeps one queued frame request and flags requests that had to be dropped.
module pingpong_frame_reader #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 24,
  parameter int AW    = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             buffer_ready_i,
  input  logic             buffer_sel_i,
  output logic             rd_en_o,
  output logic             rd_bank_o,
  output logic [AW-1:0]    rd_addr_o,
  input  logic [WIDTH-1:0] rd_data_i,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_valid_o,
  output logic             m_last_o,
  input  logic             m_ready_i,
  output logic             frame_done_o,
  output logic             busy_o,
  output logic             overrun_o
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   addr;
  logic [AW-1:0]   addr_nxt;
  logic            bank;
  logic            bank_nxt;
  logic            pend;
  logic            pend_nxt;
  logic            pend_bank;
  logic            pend_bank_nxt;
  logic            ovr;
  logic            ovr_nxt;

  logic [WIDTH-1:0] mem [3];
  logic [2:0]       tag;
  logic [1:0]       wp;
  logic [1:0]       rp;
  logic [1:0]       count;
  logic             inflight;
  logic             inflight_last;
  logic             addr_last;
  logic             fire;

  function automatic logic [1:0] wrap(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign addr_last = (addr == AW'(DEPTH - 1));

  // Credit counts the read already in flight, so the FIFO can never overflow.
  assign rd_en_o = (state == STREAM) &&
                   (({1'b0, count} + {2'b0, inflight}) < 3'd3);

  assign rd_bank_o    = bank;
  assign rd_addr_o    = addr;
  assign m_valid_o    = (count != 2'd0);
  assign m_data_o     = mem[rp];
  assign m_last_o     = m_valid_o & tag[rp];
  assign fire         = m_valid_o & m_ready_i;
  assign frame_done_o = (state == DRAIN) & fire & m_last_o;
  assign busy_o       = (state == STREAM) || (state == DRAIN);
  assign overrun_o    = ovr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      addr      <= '0;
      bank      <= 1'b0;
      pend      <= 1'b0;
      pend_bank <= 1'b0;
      ovr       <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      bank      <= bank_nxt;
      pend      <= pend_nxt;
      pend_bank <= pend_bank_nxt;
      ovr       <= ovr_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr;
    bank_nxt      = bank;
    pend_nxt      = pend;
    pend_bank_nxt = pend_bank;
    ovr_nxt       = ovr;
    unique case (state)
      IDLE: begin
        if (buffer_ready_i) begin
          state_nxt = STREAM;
          bank_nxt  = buffer_sel_i;
          addr_nxt  = '0;
        end
      end
      STREAM: begin
        if (buffer_ready_i) begin
          if (pend) begin
            ovr_nxt = 1'b1;
          end else begin
            pend_nxt      = 1'b1;
            pend_bank_nxt = buffer_sel_i;
          end
        end
        if (rd_en_o) begin
          if (addr_last) begin
            state_nxt = DRAIN;
          end else begin
            addr_nxt = addr + AW'(1);
          end
        end
      end
      DRAIN: begin
        if (frame_done_o) begin
          // Queued request wins; a fresh pulse this cycle takes its slot.
          if (pend) begin
            state_nxt     = STREAM;
            bank_nxt      = pend_bank;
            addr_nxt      = '0;
            pend_nxt      = buffer_ready_i;
            pend_bank_nxt = buffer_ready_i ? buffer_sel_i : pend_bank;
          end else if (buffer_ready_i) begin
            state_nxt = STREAM;
            bank_nxt  = buffer_sel_i;
            addr_nxt  = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else if (buffer_ready_i) begin
          if (pend) begin
            ovr_nxt = 1'b1;
          end else begin
            pend_nxt      = 1'b1;
            pend_bank_nxt = buffer_sel_i;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 3; i++) begin
        mem[i] <= '0;
      end
      tag           <= '0;
      wp            <= '0;
      rp            <= '0;
      count         <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= rd_en_o;
      inflight_last <= rd_en_o & addr_last;
      if (inflight) begin
        mem[wp] <= rd_data_i;
        tag[wp] <= inflight_last;
        wp      <= wrap(wp);
      end
      if (fire) begin
        rp <= wrap(rp);
      end
      unique case (1'b1)
        inflight && !fire: count <= count + 2'd1;
        fire && !inflight: count <= count - 2'd1;
        default: ;
      endcase
    end
  end

endmodule
